// File: rtl/multdiv_iter_if.sv
// Start/result bus for the iterative multiply/divide unit.
// Handshake: exactly one of ctrl_MULT/ctrl_DIV high at a rising edge starts an operation (operands and is_signed sampled there);
// data_resultRDY is a one-cycle pulse during which data_result/data_result_hi/data_exception are valid; busy is high while an op is in flight.
interface multdiv_iter_if #(parameter int WIDTH = 32);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             is_signed;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_result_hi;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, is_signed, data_operandA, data_operandB,
    input  data_result, data_result_hi, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, is_signed, data_operandA, data_operandB,
    output data_result, data_result_hi, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Operands are reduced to magnitudes up front and the signs are reapplied in FIX.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  multdiv_iter_if.slave bus,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_div, op_signed, neg_a, neg_b;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] hi_q, lo_q, div_q;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_exc;

  logic             start;
  logic [WIDTH:0]   add_sum, shifted, trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod, prod_fix;
  logic             neg_p, fix_exc;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign start = bus.ctrl_MULT ^ bus.ctrl_DIV;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A valid start wins in every state, which is how restart aborts an op in flight.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = PREP;
    end else begin
      case (state)
        PREP:    if (cnt == CNT_W'(1)) state_nxt = (op_div && op_b == '0) ? DONE : ITER;
        ITER:    if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Multiply: lo holds the multiplier, hi accumulates; divide: {hi,lo} = {remainder, quotient}.
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, div_q} : {(WIDTH+1){1'b0}});
    mul_next = {add_sum, lo_q[WIDTH-1:1]};
    shifted  = {hi_q, lo_q[WIDTH-1]};
    trial    = shifted - {1'b0, div_q};
    if (!trial[WIDTH]) div_next = {trial[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b1};
    else               div_next = {shifted[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b0};

    neg_p    = neg_a ^ neg_b;
    prod     = {hi_q, lo_q};
    prod_fix = neg_p ? (~prod + 1'b1) : prod;
    quo_fix  = neg_p ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_a ? (~hi_q + 1'b1) : hi_q;
    if (op_div)         fix_exc = op_signed && (op_a == MIN_VAL) && (op_b == '1);
    else if (op_signed) fix_exc = prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}};
    else                fix_exc = prod_fix[2*WIDTH-1:WIDTH] != '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= '0;
      res_lo    <= '0;
      res_hi    <= '0;
      res_exc   <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      op_div    <= bus.ctrl_DIV;
      op_signed <= bus.is_signed;
      op_a      <= bus.data_operandA;
      op_b      <= bus.data_operandB;
    end else begin
      case (state)
        PREP: begin
          if (cnt == '0) begin
            neg_a <= op_signed & op_a[WIDTH-1];
            neg_b <= op_signed & op_b[WIDTH-1];
            lo_q  <= mag(op_a, op_signed);
            div_q <= mag(op_b, op_signed);
            hi_q  <= '0;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
            if (op_div && op_b == '0) begin
              res_lo  <= '0;
              res_hi  <= '0;
              res_exc <= 1'b1;
            end
          end
        end
        ITER: begin
          {hi_q, lo_q} <= op_div ? div_next : mul_next;
          cnt          <= cnt + CNT_W'(1);
        end
        FIX: begin
          res_lo  <= op_div ? quo_fix : prod_fix[WIDTH-1:0];
          res_hi  <= op_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          res_exc <= fix_exc;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = res_lo;
  assign bus.data_result_hi = res_hi;
  assign bus.data_exception = res_exc;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);
  assign state_dbg          = state;

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: directed cases plus random ops, checked through an expected-result queue.
module tb_multdiv_iter;
  localparam int W  = 32;
  localparam int EW = 32 + 1 + 2*W;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  multdiv_iter_if #(.WIDTH(W)) bus();
  logic [2:0] state_dbg;

  multdiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // scoreboard: {expected rdy cycle, exception, hi, lo}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands.
  function automatic logic [EW-1:0] model(input bit div, input bit sgn,
                                          input logic [W-1:0] a, input logic [W-1:0] b,
                                          input int rdy_cyc);
    longint     sp, sa, sb, q, r, lim;
    logic [63:0] up;
    logic        exc;
    logic [W-1:0] lo, hi;
    lim = longint'(1) << (W-1);
    if (!div) begin
      if (sgn) begin
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = sp;
        exc = (sp >= lim) || (sp < -lim);
      end else begin
        up  = 64'(a) * 64'(b);
        exc = up >= (64'd1 << W);
      end
      lo = up[W-1:0];
      hi = up[2*W-1:W];
    end else if (b == '0) begin
      exc = 1'b1; lo = '0; hi = '0;
    end else if (sgn) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = sa / sb;
      r   = sa % sb;
      lo  = q[W-1:0];
      hi  = r[W-1:0];
      exc = (a == MIN_VAL) && (b == '1);
    end else begin
      lo = a / b; hi = a % b; exc = 1'b0;
    end
    return {rdy_cyc[31:0], exc, hi, lo};
  endfunction

  // driver
  task automatic issue(input bit div, input bit sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push);
    int lat;
    @(posedge clock); #1;
    bus.ctrl_MULT     = !div;
    bus.ctrl_DIV      = div;
    bus.is_signed     = sgn;
    bus.data_operandA = a;
    bus.data_operandB = b;
    lat = (div && b == '0) ? 2 : W + 3;
    if (push) exp_q.push_back(model(div, sgn, a, b, cyc + 1 + lat));
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.is_signed     = 1'($urandom_range(0, 1));
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 64'(bus.busy), 64'd0);
    @(negedge clock);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return MIN_VAL;
      1:       return '1;
      2:       return W'(1);
      3:       return W'($urandom_range(0, 100));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int bad;
    logic [W-1:0] ra, rb;
    bit rdiv, rsgn;

    reset = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.is_signed = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    // monitor
    fork
      forever begin
        @(negedge clock);
        if (bus.data_resultRDY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdy cycle=%0d result=%0h hi=%0h", cyc, bus.data_result, bus.data_result_hi);
          end else begin
            mon_e = exp_q.pop_front();
            check("rdy_cycle", 64'(cyc), 64'(mon_e[EW-1 -: 32]));
            check("result", 64'(bus.data_result), 64'(mon_e[W-1:0]));
            check("result_hi", 64'(bus.data_result_hi), 64'(mon_e[2*W-1:W]));
            check("exception", 64'(bus.data_exception), 64'(mon_e[2*W]));
          end
        end
      end
    join_none

    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
    check("rst_result", {bus.data_result_hi, bus.data_result}, 64'd0);
    check("rst_exc", 64'(bus.data_exception), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // unsigned 6 x 7 with busy span check
    issue(1'b0, 1'b0, W'(6), W'(7), 1'b1);
    bad = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (!bus.busy) bad++;
    end
    check("busy_span", 64'(bad), 64'd0);
    @(negedge clock);
    check("busy_after", 64'(bus.busy), 64'd0);

    issue(1'b0, 1'b1, -W'(8), W'(10), 1'b1);          wait_idle();
    issue(1'b0, 1'b0, W'(32'h10000), W'(32'h10000), 1'b1); wait_idle();
    issue(1'b1, 1'b1, W'(37), W'(9), 1'b1);           wait_idle();
    issue(1'b1, 1'b1, -W'(37), W'(5), 1'b1);          wait_idle();
    issue(1'b1, 1'b1, MIN_VAL, '1, 1'b1);             wait_idle();
    issue(1'b1, 1'b0, W'(12), W'(0), 1'b1);           wait_idle();

    // both ctrl lines together: no start, outputs hold the divide-by-zero result
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV  = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.busy) bad++;
    end
    check("both_ctrl_busy", 64'(bad), 64'd0);
    check("hold_exc", 64'(bus.data_exception), 64'd1);
    check("hold_result", {bus.data_result_hi, bus.data_result}, 64'd0);

    // restart: MULT aborted by DIV at E+10
    issue(1'b0, 1'b0, W'(3), W'(5), 1'b0);
    repeat (8) @(posedge clock);
    issue(1'b1, 1'b1, W'(100), W'(7), 1'b1);
    wait_idle();

    // reset in the middle of a multiply
    issue(1'b0, 1'b0, W'(9), W'(11), 1'b0);
    repeat (20) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_result", {bus.data_result_hi, bus.data_result}, 64'd0);
    check("midrst_exc", 64'(bus.data_exception), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (50) @(negedge clock);
    check("midrst_idle", 64'(bus.busy), 64'd0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      rdiv = 1'($urandom_range(0, 1));
      rsgn = 1'($urandom_range(0, 1));
      ra   = pick_val();
      rb   = ($urandom_range(0, 7) == 0) ? '0 : pick_val();
      issue(rdiv, rsgn, ra, rb, 1'b1);
      wait_idle();
    end

    repeat (5) @(negedge clock);
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
